// File: rtl/keyboard_pkg.sv
// keyboard_pkg: shared PS/2 prefix codes, RAM word layout and frame FSM encoding
package keyboard_pkg;
  localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
  localparam logic [7:0] PS2_BRK_PREFIX = 8'hF0;
  localparam int EXT_FLAG_BIT = 8;
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY, STOP} frame_state_t;
endpackage

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: synchronises the PS/2 pins and assembles 11-bit frames into bytes; odd parity checked when PS2_PARITY_CHECK_EN is defined
module ps2_frame_rx
  import keyboard_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic       iPS2Clock,
  input  logic       iPS2Data,
  output logic [7:0] oByte,
  output logic       oByteValid,
  output logic       oParityError
);
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);
  logic [1:0] clk_sync, dat_sync;
  logic clk_prev, fall, bit_d, timeout, par_ok;
  logic [2:0] bit_cnt;
  logic [TW-1:0] tcnt;
  frame_state_t state, state_n;
  assign fall = clk_prev & ~clk_sync[1];
  assign bit_d = dat_sync[1];
  assign timeout = tcnt == TMAX;
  // two-stage synchronisers plus the delayed clock level used for edge detection
  always_ff @(posedge Clock or negedge Reset_n)
    if (!Reset_n) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], iPS2Clock};
      dat_sync <= {dat_sync[0], iPS2Data};
      clk_prev <= clk_sync[1];
    end
  // frame state register
  always_ff @(posedge Clock or negedge Reset_n)
    if (!Reset_n) state <= IDLE;
    else state <= state_n;
  // advance on each PS/2 falling edge; a stalled partial frame falls back to IDLE
  always_comb begin
    state_n = state;
    if (fall)
      case (state)
        IDLE:    state_n = bit_d ? IDLE : SHIFT;
        SHIFT:   state_n = (bit_cnt == 3'd7) ? PARITY : SHIFT;
        PARITY:  state_n = STOP;
        default: state_n = IDLE;
      endcase
    else if (timeout)
      state_n = IDLE;
  end
  // shift register, bit counter, saturating timeout counter and frame result pulses
  always_ff @(posedge Clock or negedge Reset_n)
    if (!Reset_n) begin
      bit_cnt      <= '0;
      oByte        <= '0;
      tcnt         <= '0;
      oByteValid   <= 1'b0;
      oParityError <= 1'b0;
    end else begin
      tcnt         <= fall ? '0 : timeout ? tcnt : tcnt + 1'b1;
      oByteValid   <= fall && state == STOP && bit_d && par_ok;
      oParityError <= fall && state == STOP && !par_ok;
      if (fall) begin
        bit_cnt <= (state == SHIFT) ? bit_cnt + 1'b1 : '0;
        if (state == SHIFT) oByte <= {bit_d, oByte[7:1]};
      end
    end
`ifdef PS2_PARITY_CHECK_EN
  // odd parity over the eight data bits and the parity bit, judged at the parity edge
  always_ff @(posedge Clock or negedge Reset_n)
    if (!Reset_n) par_ok <= 1'b1;
    else if (fall && state == PARITY) par_ok <= ^{oByte, bit_d};
`else
  assign par_ok = 1'b1;
`endif
endmodule

// File: rtl/ps2_scancode_writer.sv
// ps2_scancode_writer: decodes PS/2 make/break/extended bytes and writes make codes into the scan-code RAM; parity checking via PS2_PARITY_CHECK_EN
module ps2_scancode_writer
  import keyboard_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 8,
  parameter int MEM_SIZE       = 8,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic                  Clock,
  input  logic                  Reset_n,
  input  logic                  iPS2Clock,
  input  logic                  iPS2Data,
  input  logic                  iClear,
  output logic                  oWriteEnable,
  output logic [ADDR_WIDTH-1:0] oWriteAddress,
  output logic [DATA_WIDTH-1:0] oWriteData,
  output logic [7:0]            oLastCode,
  output logic                  oParityError
);
  logic [7:0] rx_byte;
  logic rx_valid, ext, brk, is_make, do_write;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [DATA_WIDTH-1:0] word;
  ps2_frame_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .Clock        (Clock),
    .Reset_n      (Reset_n),
    .iPS2Clock    (iPS2Clock),
    .iPS2Data     (iPS2Data),
    .oByte        (rx_byte),
    .oByteValid   (rx_valid),
    .oParityError (oParityError)
  );
  assign is_make = rx_valid && rx_byte != PS2_EXT_PREFIX && rx_byte != PS2_BRK_PREFIX;
  assign do_write = is_make && !brk && !iClear;
  // RAM word: code in the low byte, extended flag above it, remaining bits zero
  always_comb begin
    word = '0;
    word[7:0] = rx_byte;
    word[EXT_FLAG_BIT] = ext;
  end
  // prefix flags, write pointer and registered RAM write port
  always_ff @(posedge Clock or negedge Reset_n)
    if (!Reset_n) begin
      oWriteEnable  <= 1'b0;
      oWriteAddress <= '0;
      oWriteData    <= '0;
      oLastCode     <= '0;
      ptr           <= '0;
      ext           <= 1'b0;
      brk           <= 1'b0;
    end else begin
      oWriteEnable <= do_write;
      if (do_write) begin
        oWriteAddress <= ptr;
        oWriteData    <= word;
        oLastCode     <= rx_byte;
      end
      if (iClear) ptr <= '0;
      else if (oWriteEnable) ptr <= (ptr == ADDR_WIDTH'(MEM_SIZE)) ? '0 : ptr + 1'b1;
      if (iClear || is_make) begin
        ext <= 1'b0;
        brk <= 1'b0;
      end else if (rx_valid) begin
        ext <= ext | (rx_byte == PS2_EXT_PREFIX);
        brk <= brk | (rx_byte == PS2_BRK_PREFIX);
      end
    end
endmodule

// File: tb/tb_ps2_scancode_writer.sv
// tb_ps2_scancode_writer: scoreboard bench driving PS/2 frames and checking RAM writes
module tb_ps2_scancode_writer;
  localparam int MEM_SIZE = 8;
  localparam int TIMEOUT_CYCLES = 5000;
  localparam int HP = 6;
  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;
  logic Clock = 1'b0, Reset_n = 1'b0, iPS2Clock = 1'b1, iPS2Data = 1'b1, iClear = 1'b0;
  logic oWriteEnable, oParityError;
  logic [7:0] oWriteAddress, oLastCode;
  logic [15:0] oWriteData;
  wr_t q[$];
  int vectors = 0, miscompares = 0, perr_seen = 0, exp_perr = 0;
  logic [7:0] exp_ptr = '0;
  ps2_scancode_writer #(
    .DATA_WIDTH(16), .ADDR_WIDTH(8), .MEM_SIZE(MEM_SIZE), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .Clock         (Clock),
    .Reset_n       (Reset_n),
    .iPS2Clock     (iPS2Clock),
    .iPS2Data      (iPS2Data),
    .iClear        (iClear),
    .oWriteEnable  (oWriteEnable),
    .oWriteAddress (oWriteAddress),
    .oWriteData    (oWriteData),
    .oLastCode     (oLastCode),
    .oParityError  (oParityError)
  );
  always #5 Clock = ~Clock;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic expect_write(input logic [15:0] data);
    wr_t e;
    e.addr = exp_ptr;
    e.data = data;
    q.push_back(e);
    exp_ptr = (exp_ptr == 8'(MEM_SIZE)) ? 8'd0 : exp_ptr + 8'd1;
  endtask
  task automatic send(input logic [7:0] b, input bit bad_par, input bit stop, input int nbits, input bit clr);
    logic [10:0] f;
    f = {stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      iPS2Data = f[i];
      repeat (HP) @(negedge Clock);
      iPS2Clock = 1'b0;
      if (clr && i == 10) iClear = 1'b1;
      repeat (HP) @(negedge Clock);
      iClear = 1'b0;
      iPS2Clock = 1'b1;
    end
    iPS2Data = 1'b1;
    repeat (4 * HP) @(negedge Clock);
  endtask
  task automatic key(input logic [7:0] b);
    send(b, 1'b0, 1'b1, 11, 1'b0);
  endtask
  always @(negedge Clock) begin
    if (Reset_n && oWriteEnable) begin
      if (q.size() == 0) chk("spurious_we", oWriteEnable, 1'b0);
      else begin
        wr_t e;
        e = q.pop_front();
        chk("waddr", oWriteAddress, e.addr);
        chk("wdata", oWriteData, e.data);
        chk("lastcode", oLastCode, e.data[7:0]);
      end
    end
    if (Reset_n && oParityError) perr_seen++;
  end
  initial begin
    repeat (3) @(negedge Clock);
    chk("rst_we", oWriteEnable, 0);
    chk("rst_addr", oWriteAddress, 0);
    chk("rst_data", oWriteData, 0);
    chk("rst_last", oLastCode, 0);
    chk("rst_perr", oParityError, 0);
    Reset_n = 1'b1;
    repeat (5) @(negedge Clock);
    expect_write(16'h001C);
    key(8'h1C);
    chk("t1_last", oLastCode, 8'h1C);
    chk("t1_pending", q.size(), 0);
    key(8'hF0);
    key(8'h1C);
    expect_write(16'h0032);
    key(8'h32);
    chk("t2_pending", q.size(), 0);
    key(8'hE0);
    expect_write(16'h0175);
    key(8'h75);
    key(8'hE0);
    key(8'hF0);
    key(8'h75);
    expect_write(16'h0016);
    key(8'h16);
    chk("t3_pending", q.size(), 0);
    iClear = 1'b1;
    @(negedge Clock);
    iClear = 1'b0;
    exp_ptr = '0;
    for (int i = 0; i < MEM_SIZE + 2; i++) begin
      expect_write(16'h0020 + 16'(i));
      key(8'h20 + 8'(i));
    end
    chk("t4_wrap_pending", q.size(), 0);
    send(8'h4D, 1'b0, 1'b1, 11, 1'b1);
    exp_ptr = '0;
    expect_write(16'h004E);
    key(8'h4E);
    chk("t4_clear_pending", q.size(), 0);
    send(8'h3A, 1'b0, 1'b0, 11, 1'b0);
    send(8'h00, 1'b0, 1'b1, 5, 1'b0);
    repeat (TIMEOUT_CYCLES + 20) @(negedge Clock);
    expect_write(16'h001C);
    key(8'h1C);
    chk("t5_timeout_pending", q.size(), 0);
    send(8'hAA, 1'b0, 1'b1, 6, 1'b0);
    Reset_n = 1'b0;
    repeat (2) @(negedge Clock);
    chk("t5_rst_we", oWriteEnable, 0);
    chk("t5_rst_addr", oWriteAddress, 0);
    chk("t5_rst_data", oWriteData, 0);
    chk("t5_rst_last", oLastCode, 0);
    Reset_n = 1'b1;
    exp_ptr = '0;
    repeat (5) @(negedge Clock);
    expect_write(16'h0022);
    key(8'h22);
    chk("t5_recover_pending", q.size(), 0);
`ifdef PS2_PARITY_CHECK_EN
    exp_perr = 1;
`else
    expect_write(16'h001C);
`endif
    send(8'h1C, 1'b1, 1'b1, 11, 1'b0);
    chk("t6_pending", q.size(), 0);
    chk("t6_perr_count", perr_seen, exp_perr);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
